// File: rtl/operand_accumulator_if.sv
// Operand/result handshake bundle for operand_accumulator.
// The slave side is the accumulator; the master side is the operand source and result consumer.
interface operand_accumulator_if #(
    parameter int unsigned WIDTH   = 6,
    parameter int unsigned COUNT_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_sum;
    logic               out_carry;
    logic [COUNT_W-1:0] out_count;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_carry, out_count
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_carry, out_count
    );
endinterface

// File: rtl/operand_accumulator.sv
// Folds a stream of operands into a ripple-carry running sum and presents the
// group result with a sticky carry-out and a saturating beat count.
module operand_accumulator #(
    parameter int unsigned WIDTH   = 6,
    parameter int unsigned COUNT_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    operand_accumulator_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               carry_q, carry_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_sum_q, out_sum_d;
    logic               out_carry_q, out_carry_d;
    logic [COUNT_W-1:0] out_count_q, out_count_d;

    logic               in_xfer;
    logic               out_xfer;
    logic [WIDTH:0]     rca_c;
    logic [WIDTH-1:0]   rca_s;

    assign bus.in_ready  = !reset && (state_q != HOLD);
    assign in_xfer       = bus.in_valid && bus.in_ready;
    assign out_xfer      = out_valid_q && bus.out_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_carry = out_carry_q;
    assign bus.out_count = out_count_q;

    // Ripple-carry adder: acc_q + in_data, carry out of the top bit in rca_c[WIDTH].
    assign rca_c[0] = 1'b0;
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_rca
        assign rca_s[i]   = acc_q[i] ^ bus.in_data[i] ^ rca_c[i];
        assign rca_c[i+1] = (acc_q[i] & bus.in_data[i]) | (rca_c[i] & (acc_q[i] ^ bus.in_data[i]));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_carry_q <= 1'b0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_carry_q <= out_carry_d;
            out_count_q <= out_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_xfer) state_d = bus.in_last ? HOLD : ACCUM;
            ACCUM:   if (in_xfer) state_d = bus.in_last ? HOLD : ACCUM;
            HOLD:    if (out_xfer) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and result registers; the result is captured on the edge entering HOLD.
    always_comb begin
        acc_d       = acc_q;
        carry_d     = carry_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_carry_d = out_carry_q;
        out_count_d = out_count_q;
        unique case (state_q)
            IDLE: begin
                if (in_xfer) begin
                    acc_d   = bus.in_data;
                    carry_d = 1'b0;
                    count_d = COUNT_W'(1);
                end
            end
            ACCUM: begin
                if (in_xfer) begin
                    acc_d   = rca_s;
                    carry_d = carry_q | rca_c[WIDTH];
                    if (count_q != {COUNT_W{1'b1}}) count_d = count_q + COUNT_W'(1);
                end
            end
            HOLD: begin
                if (out_xfer) begin
                    out_valid_d = 1'b0;
                    out_sum_d   = '0;
                    out_carry_d = 1'b0;
                    out_count_d = '0;
                end
            end
            default: ;
        endcase
        if ((state_q != HOLD) && (state_d == HOLD)) begin
            out_valid_d = 1'b1;
            out_sum_d   = acc_d;
            out_carry_d = carry_d;
            out_count_d = count_d;
        end
    end
endmodule

// File: tb/tb_operand_accumulator.sv
// Directed self-checking bench for operand_accumulator with hand-computed results.
module tb_operand_accumulator;
    localparam int unsigned WIDTH   = 6;
    localparam int unsigned COUNT_W = 4;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    operand_accumulator_if #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) ifc ();

    operand_accumulator #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input int s, input logic c, input int n);
        chk({tag, ".valid"}, 32'(ifc.out_valid), 32'(v));
        chk({tag, ".sum"},   32'(ifc.out_sum),   32'(s));
        chk({tag, ".carry"}, 32'(ifc.out_carry), 32'(c));
        chk({tag, ".count"}, 32'(ifc.out_count), 32'(n));
    endtask

    task automatic beat(input int d, input logic last);
        ifc.in_valid = 1'b1;
        ifc.in_data  = WIDTH'(d);
        ifc.in_last  = last;
        step();
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
        ifc.in_data  = '0;
    endtask

    task automatic drain(input string tag);
        ifc.out_ready = 1'b1;
        step();
        ifc.out_ready = 1'b0;
        chk_out({tag, ".drain"}, 1'b0, 0, 1'b0, 0);
        chk({tag, ".rdy"}, 32'(ifc.in_ready), 32'd1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        ifc.in_valid  = 1'b0;
        ifc.in_data   = '0;
        ifc.in_last   = 1'b0;
        ifc.out_ready = 1'b0;
        step();
        step();
        chk_out("reset", 1'b0, 0, 1'b0, 0);
        chk("reset.rdy", 32'(ifc.in_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("idle.rdy", 32'(ifc.in_ready), 32'd1);

        // 15 + 33 with a stall in ACCUM between beats
        beat(15, 1'b0);
        chk_out("t1.mid", 1'b0, 0, 1'b0, 0);
        for (int i = 0; i < 3; i++) step();
        chk_out("t1.stall", 1'b0, 0, 1'b0, 0);
        chk("t1.stall.rdy", 32'(ifc.in_ready), 32'd1);
        beat(33, 1'b1);
        chk_out("t1", 1'b1, 48, 1'b0, 2);
        chk("t1.rdy", 32'(ifc.in_ready), 32'd0);
        drain("t1");

        beat(40, 1'b0);
        beat(30, 1'b1);
        chk_out("t2", 1'b1, 6, 1'b1, 2);
        drain("t2");

        beat(63, 1'b1);
        chk_out("t3", 1'b1, 63, 1'b0, 1);
        drain("t3");

        // Sticky carry survives a later add that does not wrap
        beat(60, 1'b0);
        beat(10, 1'b0);
        beat(1, 1'b1);
        chk_out("sticky", 1'b1, 7, 1'b1, 3);
        drain("sticky");

        // Backpressure with a pending operand offered during HOLD
        beat(5, 1'b0);
        beat(7, 1'b1);
        ifc.in_valid = 1'b1;
        ifc.in_data  = WIDTH'(9);
        ifc.in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_out("t4.hold", 1'b1, 12, 1'b0, 2);
            chk("t4.hold.rdy", 32'(ifc.in_ready), 32'd0);
        end
        ifc.out_ready = 1'b1;
        step();
        ifc.out_ready = 1'b0;
        chk_out("t4.release", 1'b0, 0, 1'b0, 0);
        chk("t4.release.rdy", 32'(ifc.in_ready), 32'd1);
        step();
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
        chk_out("t4.next", 1'b1, 9, 1'b0, 1);
        drain("t4");

        // Reset mid-group discards the partial sum
        beat(10, 1'b0);
        beat(20, 1'b0);
        reset = 1'b1;
        step();
        chk_out("t5.reset", 1'b0, 0, 1'b0, 0);
        chk("t5.reset.rdy", 32'(ifc.in_ready), 32'd0);
        reset = 1'b0;
        #1;
        beat(3, 1'b1);
        chk_out("t5", 1'b1, 3, 1'b0, 1);
        drain("t5");

        // Reset during HOLD
        beat(2, 1'b1);
        chk_out("t5h.pre", 1'b1, 2, 1'b0, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk_out("t5h.reset", 1'b0, 0, 1'b0, 0);
        chk("t5h.rdy", 32'(ifc.in_ready), 32'd1);

        // Count saturation at 15 over 17 beats
        for (int i = 0; i < 16; i++) beat(1, 1'b0);
        beat(1, 1'b1);
        chk_out("t6", 1'b1, 17, 1'b0, 15);
        drain("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
